mem_responder: RTL and testbench

- Memory-side responder for the pipelined processor's dual memory interface.
- Serves the instruction-fetch port (address_pc/q_pc, read-only) and the data port (address/data/q, MemRead/wren).
- Provides a small memory-mapped I/O window at the top of the data address space: switch input, LED output, cycle counter and sticky status.
- After reset, an init sequencer fills the RAM with the NOP encoding, so fetches from unwritten memory execute as NOPs.

---
 rtl/mem_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the pipelined core: 256x8 RAM behind an instruction-fetch
// port and a data port, with an MMIO window (switches, LEDs, cycle counter, sticky status).
module mem_responder #(
  parameter logic [7:0] INIT_VALUE = 8'h0A,
  parameter logic [7:0] MMIO_BASE  = 8'hFC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       wren,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic [7:0] q,
  input  logic [7:0] address_pc,
  output logic [7:0] q_pc,
  input  logic [4:0] sw_in,
  output logic [7:0] led_out,
  output logic       init_busy
);

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_INIT  = 1'b1;

  localparam logic [7:0] A_SW   = MMIO_BASE;
  localparam logic [7:0] A_LED  = MMIO_BASE + 8'd1;
  localparam logic [7:0] A_CNT  = MMIO_BASE + 8'd2;
  localparam logic [7:0] A_STAT = MMIO_BASE + 8'd3;

  logic [7:0] mem_q [256];

  logic [0:0] state_q, state_d;
  logic [7:0] init_addr_q, init_addr_d;
  logic [7:0] q_q, q_d;
  logic [7:0] q_pc_q, q_pc_d;
  logic [7:0] led_q, led_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] status_q, status_d;
  logic [4:0] sw_meta_q, sw_meta_d;
  logic [4:0] sw_sync_q, sw_sync_d;

  logic       mem_we_s;
  logic [7:0] mem_waddr_s;
  logic [7:0] mem_wdata_s;
  logic       data_is_ram_s;
  logic       ram_wr_s;
  logic [7:0] rd_mmio_s;
  logic [2:0] status_set_s;
  logic [2:0] status_clr_s;

  // Next-state logic for the init sweep, both read ports, MMIO registers and status.
  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    q_d           = q_q;
    q_pc_d        = q_pc_q;
    led_d         = led_q;
    cnt_d         = cnt_q + 8'd1;
    sw_meta_d     = sw_in;
    sw_sync_d     = sw_meta_q;
    status_set_s  = 3'b000;
    status_clr_s  = 3'b000;
    mem_we_s      = 1'b0;
    mem_waddr_s   = address;
    mem_wdata_s   = data;
    data_is_ram_s = (address < MMIO_BASE);
    ram_wr_s      = 1'b0;

    case (address)
      A_SW:    rd_mmio_s = {3'b000, sw_sync_q};
      A_LED:   rd_mmio_s = led_q;
      A_CNT:   rd_mmio_s = cnt_q;
      default: rd_mmio_s = {5'b00000, status_q};
    endcase

    if (state_q == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = init_addr_q;
      mem_wdata_s = INIT_VALUE;
      init_addr_d = init_addr_q + 8'd1;
      q_pc_d      = INIT_VALUE;
      if (init_addr_q == 8'hFF) begin
        state_d = ST_READY;
      end else begin
        state_d = ST_INIT;
      end
      if (MemRead) begin
        q_d = 8'h00;
      end else begin
        q_d = q_q;
      end
      // Writes during the sweep are dropped but leave a sticky trace.
      if (wren) begin
        status_set_s[0] = 1'b1;
      end else begin
        status_set_s[0] = 1'b0;
      end
    end else begin
      ram_wr_s = wren && data_is_ram_s;
      mem_we_s = ram_wr_s;
      if (MemRead) begin
        if (ram_wr_s) begin
          q_d = data;
        end else if (data_is_ram_s) begin
          q_d = mem_q[address];
        end else if (wren && (address == A_LED)) begin
          q_d = data;
        end else begin
          q_d = rd_mmio_s;
        end
      end else begin
        q_d = q_q;
      end
      // Fetch bypasses a same-cycle data write to the same word and flags the collision.
      if (ram_wr_s && (address == address_pc)) begin
        q_pc_d          = data;
        status_set_s[2] = 1'b1;
      end else begin
        q_pc_d = mem_q[address_pc];
      end
      if (wren) begin
        case (address)
          A_SW:    status_set_s[1] = 1'b1;
          A_LED:   led_d           = data;
          A_CNT:   status_set_s[1] = 1'b1;
          A_STAT:  status_clr_s    = data[2:0];
          default: led_d           = led_q;
        endcase
      end else begin
        led_d = led_q;
      end
    end

    status_d = (status_q & ~status_clr_s) | status_set_s;
  end

  // Control and MMIO state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= 8'h00;
      q_q         <= 8'h00;
      q_pc_q      <= INIT_VALUE;
      led_q       <= 8'h00;
      cnt_q       <= 8'h00;
      status_q    <= 3'b000;
      sw_meta_q   <= 5'b00000;
      sw_sync_q   <= 5'b00000;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      q_q         <= q_d;
      q_pc_q      <= q_pc_d;
      led_q       <= led_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
    end
  end

  // RAM array is deliberately unreset; the init sweep fills it.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign q         = q_q;
  assign q_pc      = q_pc_q;
  assign led_out   = led_q;
  assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: init sweep, data/fetch ports, MMIO, reset abort.
module tb_mem_responder;

  logic       clock;
  logic       reset;
  logic       MemRead;
  logic       wren;
  logic [7:0] address;
  logic [7:0] data;
  logic [7:0] q;
  logic [7:0] address_pc;
  logic [7:0] q_pc;
  logic [4:0] sw_in;
  logic [7:0] led_out;
  logic       init_busy;

  int checks = 0;
  int errors = 0;

  mem_responder dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .wren(wren),
    .address(address), .data(data), .q(q), .address_pc(address_pc),
    .q_pc(q_pc), .sw_in(sw_in), .led_out(led_out), .init_busy(init_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one data-port operation at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    MemRead = rd;
    wren    = wr;
    address = a;
    data    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b0;
    #12;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h exp %h", q, 8'h00); end
    checks++; if (q_pc !== 8'h0A) begin errors++; $display("FAIL reset_q_pc: got %h exp %h", q_pc, 8'h0A); end
    checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led: got %h exp %h", led_out, 8'h00); end
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b exp 1", init_busy); end
    @(negedge clock);
    reset = 1'b1;
    count_init(n);
    checks++; if (n !== 256) begin errors++; $display("FAIL init_edges: got %0d exp 256", n); end
    @(negedge clock); address_pc = 8'h00; @(posedge clock); #1;
    checks++; if (q_pc !== 8'h0A) begin errors++; $display("FAIL fetch_00: got %h exp %h", q_pc, 8'h0A); end
    @(negedge clock); address_pc = 8'h7F; @(posedge clock); #1;
    checks++; if (q_pc !== 8'h0A) begin errors++; $display("FAIL fetch_7f: got %h exp %h", q_pc, 8'h0A); end
    @(negedge clock); address_pc = 8'hFF; @(posedge clock); #1;
    checks++; if (q_pc !== 8'h0A) begin errors++; $display("FAIL fetch_ff: got %h exp %h", q_pc, 8'h0A); end
    cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL status_after_init: got %h exp %h", q, 8'h00); end
  endtask

  task automatic test_write_read;
    cycle(1'b0, 1'b1, 8'h10, 8'h3C);
    cycle(1'b1, 1'b0, 8'h10, 8'h00);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL rd_after_wr: got %h exp %h", q, 8'h3C); end
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL q_hold: got %h exp %h", q, 8'h3C); end
  endtask

  task automatic test_write_first;
    @(negedge clock);
    address_pc = 8'h20;
    cycle(1'b1, 1'b1, 8'h20, 8'h5A);
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL wf_q: got %h exp %h", q, 8'h5A); end
    checks++; if (q_pc !== 8'h5A) begin errors++; $display("FAIL wf_q_pc: got %h exp %h", q_pc, 8'h5A); end
    cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    checks++; if (q !== 8'h04) begin errors++; $display("FAIL wf_status: got %h exp %h", q, 8'h04); end
    cycle(1'b0, 1'b1, 8'hFF, 8'h04);
    cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL wf_status_clr: got %h exp %h", q, 8'h00); end
  endtask

  task automatic test_mmio;
    logic [7:0] c;
    cycle(1'b0, 1'b1, 8'hFD, 8'hA5);
    checks++; if (led_out !== 8'hA5) begin errors++; $display("FAIL led_write: got %h exp %h", led_out, 8'hA5); end
    cycle(1'b1, 1'b0, 8'hFD, 8'h00);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL led_read: got %h exp %h", q, 8'hA5); end
    cycle(1'b1, 1'b0, 8'hFE, 8'h00);
    c = q;
    cycle(1'b0, 1'b1, 8'hFE, 8'h00);
    cycle(1'b1, 1'b0, 8'hFE, 8'h00);
    checks++; if (q !== c + 8'd2) begin errors++; $display("FAIL cnt_wr_ignored: got %h exp %h", q, c + 8'd2); end
    cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    checks++; if (q !== 8'h02) begin errors++; $display("FAIL status_s1: got %h exp %h", q, 8'h02); end
    cycle(1'b0, 1'b1, 8'hFF, 8'h02);
    cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL status_w1c: got %h exp %h", q, 8'h00); end
  endtask

  task automatic test_switch_counter;
    logic [7:0] prev;
    logic       wrapped;
    @(negedge clock);
    sw_in = 5'b10110;
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'hFC, 8'h00);
    checks++; if (q !== 8'h16) begin errors++; $display("FAIL sw_read: got %h exp %h", q, 8'h16); end
    cycle(1'b1, 1'b0, 8'hFE, 8'h00);
    prev    = q;
    wrapped = 1'b0;
    for (int i = 0; i < 260; i++) begin
      @(posedge clock);
      #1;
      checks++; if (q !== prev + 8'd1) begin errors++; $display("FAIL cnt_step: got %h exp %h", q, prev + 8'd1); end
      if (prev == 8'hFF) wrapped = 1'b1;
      prev = q;
    end
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL cnt_wrap: got %b exp 1", wrapped); end
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_init_abort;
    int n;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i < 50; i++) begin
      @(posedge clock);
    end
    cycle(1'b0, 1'b1, 8'hFD, 8'h5C);
    checks++; if (led_out !== 8'hA5 && led_out !== 8'h00) begin errors++; $display("FAIL init_drop_sanity: got %h", led_out); end
    checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL init_write_dropped: got %h exp %h", led_out, 8'h00); end
    cycle(1'b1, 1'b0, 8'hFE, 8'h00);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL init_read_zero: got %h exp %h", q, 8'h00); end
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL init_busy_mid: got %b exp 1", init_busy); end
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 53; i <= 100; i++) begin
      @(posedge clock);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b exp 1", init_busy); end
    @(negedge clock);
    reset = 1'b1;
    count_init(n);
    checks++; if (n !== 256) begin errors++; $display("FAIL abort_init_edges: got %0d exp 256", n); end
    cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL abort_status: got %h exp %h", q, 8'h00); end
  endtask

  task automatic test_init_status;
    int n;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i < 50; i++) begin
      @(posedge clock);
    end
    cycle(1'b0, 1'b1, 8'h30, 8'h77);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    count_init(n);
    checks++; if (n !== 205) begin errors++; $display("FAIL status_init_edges: got %0d exp 205", n); end
    cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL init_write_status: got %h exp %h", q, 8'h01); end
    cycle(1'b1, 1'b0, 8'h30, 8'h00);
    checks++; if (q !== 8'h0A) begin errors++; $display("FAIL init_write_ram: got %h exp %h", q, 8'h0A); end
  endtask

  initial begin
    reset      = 1'b0;
    MemRead    = 1'b0;
    wren       = 1'b0;
    address    = 8'h00;
    data       = 8'h00;
    address_pc = 8'h00;
    sw_in      = 5'b00000;
    test_reset();
    test_write_read();
    test_write_first();
    test_mmio();
    test_switch_counter();
    test_init_abort();
    test_init_status();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
